// File: rtl/ballot_pkg.sv
// Shared constants and types for the ballot collector front end.
package ballot_pkg;

  localparam int NUM_VOTERS     = 8;
  localparam int CHOICE_W       = 2;
  localparam int DEFAULT_CHOICE = 0;
  localparam int ID_W           = $clog2(NUM_VOTERS);
  localparam int TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } collector_state_t;

endpackage

// File: rtl/ballot_idle_timer.sv
// Idle counter for the collection window. Exists only when
// BALLOT_COLLECTOR_TIMEOUT_EN is defined; otherwise this file is empty.
// Counts every cycle that clr is low and raises expire during the cycle
// in which the count sits at TIMEOUT_CYCLES-1.
`ifdef BALLOT_COLLECTOR_TIMEOUT_EN
module ballot_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Idle counter: restart on clear, otherwise advance by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = !clr && (count_q == LAST);

endmodule
`endif

// File: rtl/ballot_collector.sv
// Ballot collector: gathers one ballot per voter over valid/ready, fills
// abstentions with DEFAULT_CHOICE and holds the packed vector until the tally
// side accepts it.
// Optional idle timeout: define BALLOT_COLLECTOR_TIMEOUT_EN.
module ballot_collector
  import ballot_pkg::*;
#(
  parameter int NUM_VOTERS     = ballot_pkg::NUM_VOTERS,
  parameter int CHOICE_W       = ballot_pkg::CHOICE_W,
  parameter int DEFAULT_CHOICE = ballot_pkg::DEFAULT_CHOICE,
`ifdef BALLOT_COLLECTOR_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = ballot_pkg::TIMEOUT_CYCLES,
`endif
  parameter int ID_W           = $clog2(NUM_VOTERS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           open_i,
  input  logic                           close_i,
  input  logic                           vote_valid_i,
  output logic                           vote_ready_o,
  input  logic [ID_W-1:0]                vote_id_i,
  input  logic [CHOICE_W-1:0]            vote_choice_i,
  output logic                           dup_err_o,
  output logic                           ballots_valid_o,
  input  logic                           ballots_ready_i,
  output logic [NUM_VOTERS*CHOICE_W-1:0] ballots_o,
  output logic [NUM_VOTERS-1:0]          voted_mask_o
);

  localparam int SLOT_W = $clog2(NUM_VOTERS);
  localparam logic [CHOICE_W-1:0] DEF_CODE = CHOICE_W'(DEFAULT_CHOICE);

  collector_state_t state_q, state_d;

  logic [NUM_VOTERS-1:0][CHOICE_W-1:0] slots_q;
  logic [NUM_VOTERS-1:0]               mask_q;
  logic [NUM_VOTERS-1:0]               mask_acc;
  logic [SLOT_W-1:0]                   slot_idx;
  logic                                handshake;
  logic                                in_range;
  logic                                store;
  logic                                dup_err_q;
  logic                                expire;

  // Ready is a pure decode of the state register, so there is no path
  // from vote_valid_i to vote_ready_o.
  assign handshake = (state_q == COLLECT) && vote_valid_i;
  assign in_range  = int'(vote_id_i) < NUM_VOTERS;
  assign slot_idx  = vote_id_i[SLOT_W-1:0];
  assign store     = handshake && in_range && !mask_q[slot_idx];

`ifdef BALLOT_COLLECTOR_TIMEOUT_EN
  ballot_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state_q != COLLECT) || handshake),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Mask as it will look after this cycle's accept, used to spot the last voter
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so every path drives the signal and no latch is inferred.
    mask_acc = mask_q;
    if (store) mask_acc[slot_idx] = 1'b1;
  end

  // Next-state logic for the session FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (open_i) state_d = COLLECT;
      COLLECT: if ((&mask_acc) || close_i || expire) state_d = PUBLISH;
      PUBLISH: if (ballots_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential blocks use non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Ballot storage: default fill on open, one write per accepted ballot
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this slot array is a handful of flops, not a RAM macro; it is reset
    // so a session aborted by reset can never leak stale ballots.
    if (!rst_n) begin
      slots_q <= {NUM_VOTERS{DEF_CODE}};
      mask_q  <= '0;
    end else if ((state_q == IDLE) && open_i) begin
      slots_q <= {NUM_VOTERS{DEF_CODE}};
      mask_q  <= '0;
    end else if (store) begin
      slots_q[slot_idx] <= vote_choice_i;
      mask_q            <= mask_acc;
    end
  end

  // Duplicate / out-of-range ballots are consumed and flagged one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dup_err_q <= 1'b0;
    else        dup_err_q <= handshake && !store;
  end

  assign vote_ready_o    = (state_q == COLLECT);
  assign ballots_valid_o = (state_q == PUBLISH);
  assign ballots_o       = slots_q;
  assign voted_mask_o    = mask_q;
  assign dup_err_o       = dup_err_q;

endmodule

// File: tb/tb_ballot_collector.sv
// Directed self-checking bench for ballot_collector (8 voters, 2-bit choices,
// 4-bit voter id so out-of-range ids can be driven).
// Timeout scenario runs only when BALLOT_COLLECTOR_TIMEOUT_EN is defined.
module tb_ballot_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        open_i;
  logic        close_i;
  logic        vote_valid_i;
  logic        vote_ready_o;
  logic [3:0]  vote_id_i;
  logic [1:0]  vote_choice_i;
  logic        dup_err_o;
  logic        ballots_valid_o;
  logic        ballots_ready_i;
  logic [15:0] ballots_o;
  logic [7:0]  voted_mask_o;

  int n_tests = 0;
  int n_fail  = 0;

  ballot_collector #(
    .NUM_VOTERS    (8),
    .CHOICE_W      (2),
    .DEFAULT_CHOICE(0),
`ifdef BALLOT_COLLECTOR_TIMEOUT_EN
    .TIMEOUT_CYCLES(16),
`endif
    .ID_W          (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .open_i         (open_i),
    .close_i        (close_i),
    .vote_valid_i   (vote_valid_i),
    .vote_ready_o   (vote_ready_o),
    .vote_id_i      (vote_id_i),
    .vote_choice_i  (vote_choice_i),
    .dup_err_o      (dup_err_o),
    .ballots_valid_o(ballots_valid_o),
    .ballots_ready_i(ballots_ready_i),
    .ballots_o      (ballots_o),
    .voted_mask_o   (voted_mask_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic open_session();
    open_i = 1'b1;
    step();
    open_i = 1'b0;
  endtask

  task automatic vote(input logic [3:0] id, input logic [1:0] ch);
    vote_valid_i  = 1'b1;
    vote_id_i     = id;
    vote_choice_i = ch;
    step();
    vote_valid_i  = 1'b0;
  endtask

  task automatic accept();
    ballots_ready_i = 1'b1;
    step();
    ballots_ready_i = 1'b0;
  endtask

  logic [1:0] ch_tab [8] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10};

  initial begin
    rst_n = 1'b0; open_i = 1'b0; close_i = 1'b0; vote_valid_i = 1'b0;
    vote_id_i = '0; vote_choice_i = '0; ballots_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",   32'(vote_ready_o),    32'h0);
    check("rst_valid",   32'(ballots_valid_o), 32'h0);
    check("rst_ballots", 32'(ballots_o),       32'h0);
    check("rst_mask",    32'(voted_mask_o),    32'h0);
    check("rst_dup",     32'(dup_err_o),       32'h0);
    #3 rst_n = 1'b1;

    // Full session: all eight voters, publish on the last accept
    open_session();
    check("open_ready", 32'(vote_ready_o), 32'h1);
    for (int i = 0; i < 8; i++) begin
      vote(4'(i), ch_tab[i]);
      if (i < 7) check("no_early_valid", 32'(ballots_valid_o), 32'h0);
    end
    check("full_valid",   32'(ballots_valid_o), 32'h1);
    check("full_ready",   32'(vote_ready_o),    32'h0);
    check("full_ballots", 32'(ballots_o),       32'hB58D);
    check("full_mask",    32'(voted_mask_o),    32'hFF);

    // Hold in PUBLISH with tally not ready; votes and open must be ignored
    vote_valid_i = 1'b1; vote_id_i = 4'd2; vote_choice_i = 2'b11; open_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check("hold_valid",   32'(ballots_valid_o), 32'h1);
      check("hold_ready",   32'(vote_ready_o),    32'h0);
      check("hold_ballots", 32'(ballots_o),       32'hB58D);
      check("hold_dup",     32'(dup_err_o),       32'h0);
    end
    check("hold_mask", 32'(voted_mask_o), 32'hFF);
    vote_valid_i = 1'b0; open_i = 1'b0;
    accept();
    check("idle_valid",   32'(ballots_valid_o), 32'h0);
    check("idle_ready",   32'(vote_ready_o),    32'h0);
    check("idle_ballots", 32'(ballots_o),       32'hB58D);

    // Duplicate vote for voter 3, then close
    open_session();
    check("reopen_ballots", 32'(ballots_o),    32'h0);
    check("reopen_mask",    32'(voted_mask_o), 32'h0);
    vote(4'd3, 2'b11);
    check("first_dup", 32'(dup_err_o), 32'h0);
    vote(4'd3, 2'b01);
    check("dup_pulse", 32'(dup_err_o), 32'h1);
    step();
    check("dup_clear", 32'(dup_err_o), 32'h0);
    close_i = 1'b1;
    step();
    close_i = 1'b0;
    check("close_valid",   32'(ballots_valid_o), 32'h1);
    check("close_ballots", 32'(ballots_o),       32'h00C0);
    check("close_mask",    32'(voted_mask_o),    32'h08);
    accept();

    // Out-of-range id, then a vote coinciding with close
    open_session();
    vote(4'd9, 2'b10);
    check("oor_dup",  32'(dup_err_o),    32'h1);
    check("oor_mask", 32'(voted_mask_o), 32'h00);
    check("oor_slot", 32'(ballots_o),    32'h0);
    vote(4'd5, 2'b10);
    check("v5_mask", 32'(voted_mask_o), 32'h20);
    close_i = 1'b1;
    vote(4'd2, 2'b01);
    close_i = 1'b0;
    check("vc_valid",   32'(ballots_valid_o), 32'h1);
    check("vc_mask",    32'(voted_mask_o),    32'h24);
    check("vc_ballots", 32'(ballots_o),       32'h0810);
    accept();

`ifdef BALLOT_COLLECTOR_TIMEOUT_EN
    // One vote then silence: forced close 16 edges after the handshake
    begin
      int k;
      open_session();
      vote(4'd0, 2'b11);
      k = 0;
      while (!ballots_valid_o && k < 40) begin
        step();
        k++;
      end
      check("timeout_edges",   32'(k),          32'd16);
      check("timeout_ballots", 32'(ballots_o),  32'h0003);
      check("timeout_mask",    32'(voted_mask_o), 32'h01);
      accept();
    end
`endif

    // Reset mid-session wipes everything immediately
    open_session();
    vote(4'd1, 2'b10);
    check("pre_rst_mask", 32'(voted_mask_o), 32'h02);
    vote(4'd9, 2'b01);
    check("pre_rst_dup", 32'(dup_err_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready",   32'(vote_ready_o),    32'h0);
    check("mid_rst_valid",   32'(ballots_valid_o), 32'h0);
    check("mid_rst_ballots", 32'(ballots_o),       32'h0);
    check("mid_rst_mask",    32'(voted_mask_o),    32'h0);
    check("mid_rst_dup",     32'(dup_err_o),       32'h0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'(ballots_valid_o | vote_ready_o), 32'h0);
    open_session();
    close_i = 1'b1;
    step();
    close_i = 1'b0;
    check("empty_valid",   32'(ballots_valid_o), 32'h1);
    check("empty_ballots", 32'(ballots_o),       32'h0);
    check("empty_mask",    32'(voted_mask_o),    32'h0);
    accept();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
